// File: rtl/scc_ram_scheduler_if.sv
// scc_ram_scheduler_if: bus bundle between the SCC wave RAM scheduler and its neighbours
//   ch_ptr                      wave phase pointers, ch n = ch_ptr[5n+4:5n]
//   cpu_req/wr/a/d, cpu_ack/q   CPU wave RAM access handshake
//   wave_valid/ch/q             fetched wave sample stream to the tone generators
//   sram_we/a/d, sram_q         single-port wave RAM (registered read data)
// master: requesters, tone generators and RAM side; slave: the scheduler
interface scc_ram_scheduler_if;
    logic [24:0] ch_ptr;
    logic        cpu_req;
    logic        cpu_wr;
    logic [7:0]  cpu_a;
    logic [7:0]  cpu_d;
    logic        cpu_ack;
    logic [7:0]  cpu_q;
    logic        wave_valid;
    logic [2:0]  wave_ch;
    logic [7:0]  wave_q;
    logic        sram_we;
    logic [7:0]  sram_a;
    logic [7:0]  sram_d;
    logic [7:0]  sram_q;
    modport master (
        output ch_ptr, cpu_req, cpu_wr, cpu_a, cpu_d, sram_q,
        input  cpu_ack, cpu_q, wave_valid, wave_ch, wave_q, sram_we, sram_a, sram_d
    );
    modport slave (
        input  ch_ptr, cpu_req, cpu_wr, cpu_a, cpu_d, sram_q,
        output cpu_ack, cpu_q, wave_valid, wave_ch, wave_q, sram_we, sram_a, sram_d
    );
endinterface

// File: rtl/scc_ram_scheduler.sv
// scc_ram_scheduler: time-slot sharing of the 160x8 SCC wave RAM between 5 channels and the CPU
//   clk     system clock
//   nreset  asynchronous reset, active low
//   bus     scc_ram_scheduler_if.slave (CPU handshake, wave sample stream, RAM port)
// Slots 0..4 fetch one sample per channel, slot 5 serves at most one CPU access,
// remaining slots are idle. Every access has the same 3-edge latency.
module scc_ram_scheduler #(
    parameter int FRAME_LEN = 8,
    parameter bit SCC_PLUS  = 1'b0
) (
    input  logic                 clk,
    input  logic                 nreset,
    scc_ram_scheduler_if.slave   bus
);
    localparam int SW = $clog2(FRAME_LEN);
    logic [SW-1:0] ff_slot;
    logic          ff_busy;
    logic          is_wave;
    logic          accept;
    logic          cpu_oor;
    logic [2:0]    slot_ch;
    logic [2:0]    base;
    logic [4:0]    ptr;
    // Tags travel alongside the RAM access: t1 = address issued, t2 = RAM data pending
    logic          t1_wave, t1_cpu, t1_rd, t1_oor;
    logic [2:0]    t1_ch;
    logic          t2_wave, t2_cpu, t2_rd, t2_oor;
    logic [2:0]    t2_ch;
    always_comb begin
        is_wave = ff_slot < SW'(5);
        accept  = (ff_slot == SW'(5)) && bus.cpu_req && !ff_busy;
        cpu_oor = bus.cpu_a >= 8'd160;
        slot_ch = is_wave ? ff_slot[2:0] : 3'd0;
        ptr     = 5'(bus.ch_ptr >> (5 * slot_ch));
        // Original SCC: ch4 shares the ch3 wave area
        base    = (!SCC_PLUS && slot_ch == 3'd4) ? 3'd3 : slot_ch;
    end
    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            ff_slot        <= '0;
            ff_busy        <= 1'b0;
            {t1_wave, t1_cpu, t1_rd, t1_oor, t1_ch} <= '0;
            {t2_wave, t2_cpu, t2_rd, t2_oor, t2_ch} <= '0;
            bus.sram_we    <= 1'b0;
            bus.sram_a     <= '0;
            bus.sram_d     <= '0;
            bus.wave_valid <= 1'b0;
            bus.wave_ch    <= '0;
            bus.wave_q     <= '0;
            bus.cpu_ack    <= 1'b0;
            bus.cpu_q      <= '0;
        end else begin
            ff_slot     <= (ff_slot == SW'(FRAME_LEN - 1)) ? '0 : ff_slot + 1'b1;
            bus.sram_we <= accept && bus.cpu_wr && !cpu_oor;
            if (is_wave)
                bus.sram_a <= {base, ptr};
            else if (accept && !cpu_oor)
                bus.sram_a <= bus.cpu_a;
            if (accept && !cpu_oor && bus.cpu_wr)
                bus.sram_d <= bus.cpu_d;
            t1_wave <= is_wave;
            t1_cpu  <= accept;
            t1_rd   <= !bus.cpu_wr;
            t1_oor  <= cpu_oor;
            t1_ch   <= slot_ch;
            {t2_wave, t2_cpu, t2_rd, t2_oor, t2_ch} <= {t1_wave, t1_cpu, t1_rd, t1_oor, t1_ch};
            bus.wave_valid <= t2_wave;
            if (t2_wave) begin
                bus.wave_ch <= t2_ch;
                bus.wave_q  <= bus.sram_q;
            end
            bus.cpu_ack <= t2_cpu;
            if (t2_cpu && t2_rd)
                bus.cpu_q <= t2_oor ? 8'hFF : bus.sram_q;
            // Busy drops together with the ack, long before the next CPU slot
            if (accept)
                ff_busy <= 1'b1;
            else if (t2_cpu)
                ff_busy <= 1'b0;
        end
    end
endmodule

// File: tb/tb_scc_ram_scheduler.sv
// tb_scc_ram_scheduler: randomized bench for scc_ram_scheduler against a cycle-indexed reference model
//   drives the interface master side, models the registered-read wave RAM and
//   predicts every output from the slot rules with a shadow memory and an event ring
module tb_scc_ram_scheduler;
    localparam int FL = 8;
    logic clk = 1'b0;
    logic nreset;
    always #5 clk = ~clk;
    scc_ram_scheduler_if bus ();
    scc_ram_scheduler_if bus_p ();
    scc_ram_scheduler #(.FRAME_LEN(FL), .SCC_PLUS(1'b0)) dut (.clk(clk), .nreset(nreset), .bus(bus));
    scc_ram_scheduler #(.FRAME_LEN(FL), .SCC_PLUS(1'b1)) dut_p (.clk(clk), .nreset(nreset), .bus(bus_p));
    assign bus_p.ch_ptr  = bus.ch_ptr;
    assign bus_p.cpu_req = 1'b0;
    assign bus_p.cpu_wr  = 1'b0;
    assign bus_p.cpu_a   = 8'd0;
    assign bus_p.cpu_d   = 8'd0;
    assign bus_p.sram_q  = 8'd0;
    int checks = 0;
    int errors = 0;
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask
    int unsigned salt;
    initial salt = $urandom;
    function automatic logic [7:0] seed(input int i);
        return 8'((i * 73 + 5) ^ salt);
    endfunction
    // Wave RAM: registered read, write on sram_we
    logic [7:0] mem [256];
    bit ram_init = 1'b0;
    always @(posedge clk) begin
        if (!ram_init) begin
            for (int i = 0; i < 256; i++) mem[i] <= seed(i);
            ram_init <= 1'b1;
        end else begin
            if (bus.sram_we) mem[bus.sram_a] <= bus.sram_d;
            bus.sram_q <= mem[bus.sram_a];
        end
    end
    int ack_cnt = 0;
    int we_cnt = 0;
    always @(negedge clk) if (nreset) begin
        if (bus.cpu_ack) ack_cnt++;
        if (bus.sram_we) we_cnt++;
    end
    // Reference model: expectations per future cycle, ring of 16 entries
    logic [7:0] ref_mem [256];
    bit ref_init = 1'b0;
    bit       e_wv [16], e_ack [16], e_rd [16], e_we [16], e_pa [16];
    bit [2:0] e_ch [16];
    bit [7:0] e_wq [16], e_cq [16], e_d [16], e_a [16], e_pav [16];
    bit [7:0] exp_a, exp_cq;
    bit       m_busy;
    int       n;
    always @(negedge clk) begin
        int k, k1, k3, s;
        bit [4:0] p;
        bit [7:0] a;
        if (!ref_init) begin
            for (int i = 0; i < 256; i++) ref_mem[i] = seed(i);
            ref_init = 1'b1;
        end
        if (!nreset) begin
            for (int i = 0; i < 16; i++) begin
                e_wv[i] = 0; e_ack[i] = 0; e_rd[i] = 0; e_we[i] = 0; e_pa[i] = 0;
            end
            n = 0; exp_a = 0; exp_cq = 0; m_busy = 0;
            check("rst_cpu_ack", bus.cpu_ack, 0);
            check("rst_wave_valid", bus.wave_valid, 0);
            check("rst_sram_we", bus.sram_we, 0);
        end else begin
            k = n % 16;
            if (n == 0) begin
                check("rst_slot", dut.ff_slot, 0);
                check("rst_sram_a", bus.sram_a, 0);
                check("rst_sram_d", bus.sram_d, 0);
                check("rst_wave_q", bus.wave_q, 0);
                check("rst_wave_ch", bus.wave_ch, 0);
                check("rst_cpu_q", bus.cpu_q, 0);
            end else
                check("sram_a", bus.sram_a, e_a[k]);
            check("wave_valid", bus.wave_valid, e_wv[k]);
            if (e_wv[k]) begin
                check("wave_ch", bus.wave_ch, e_ch[k]);
                check("wave_q", bus.wave_q, e_wq[k]);
            end
            check("cpu_ack", bus.cpu_ack, e_ack[k]);
            if (e_ack[k]) m_busy = 0;
            if (e_rd[k]) exp_cq = e_cq[k];
            check("cpu_q", bus.cpu_q, exp_cq);
            check("sram_we", bus.sram_we, e_we[k]);
            if (e_we[k]) check("sram_d", bus.sram_d, e_d[k]);
            if (e_pa[k]) check("plus_ch4_a", bus_p.sram_a, e_pav[k]);
            e_wv[k] = 0; e_ack[k] = 0; e_rd[k] = 0; e_we[k] = 0; e_pa[k] = 0;
            s  = n % FL;
            k1 = (n + 1) % 16;
            k3 = (n + 3) % 16;
            if (s < 5) begin
                p = bus.ch_ptr[5 * s +: 5];
                a = (s == 4) ? 8'(96 + p) : 8'(32 * s + p);
                exp_a = a;
                e_wv[k3] = 1; e_ch[k3] = 3'(s); e_wq[k3] = ref_mem[a];
                if (s == 4) begin e_pa[k1] = 1; e_pav[k1] = 8'(128 + p); end
            end else if (s == 5 && bus.cpu_req && !m_busy) begin
                m_busy = 1;
                e_ack[k3] = 1;
                if (bus.cpu_a < 160) begin
                    exp_a = bus.cpu_a;
                    if (bus.cpu_wr) begin
                        ref_mem[bus.cpu_a] = bus.cpu_d;
                        e_we[k1] = 1; e_d[k1] = bus.cpu_d;
                    end else begin
                        e_rd[k3] = 1; e_cq[k3] = ref_mem[bus.cpu_a];
                    end
                end else if (!bus.cpu_wr) begin
                    e_rd[k3] = 1; e_cq[k3] = 8'hFF;
                end
            end
            e_a[k1] = exp_a;
            n++;
        end
    end
    task automatic cpu_access(input logic wr, input logic [7:0] a, input logic [7:0] d, input int acks);
        int got = 0;
        @(posedge clk); #1;
        bus.cpu_req = 1; bus.cpu_wr = wr; bus.cpu_a = a; bus.cpu_d = d;
        for (int k = 0; k < 40 * acks && got < acks; k++) begin
            @(negedge clk);
            if (bus.cpu_ack) got++;
        end
        check("ack_seen", got, acks);
        @(posedge clk); #1 bus.cpu_req = 0;
    endtask
    initial begin
        int a0, w0;
        bit found;
        nreset = 0;
        bus.cpu_req = 0; bus.cpu_wr = 0; bus.cpu_a = 0; bus.cpu_d = 0; bus.ch_ptr = '0;
        repeat (3) @(posedge clk);
        #1 nreset = 1;
        repeat (24) @(posedge clk);
        #1 bus.ch_ptr[24:20] = 5'd31;
        repeat (16) @(posedge clk);
        w0 = we_cnt;
        cpu_access(1'b1, 8'd40, 8'h7F, 1);
        check("wr40_we_pulses", we_cnt - w0, 1);
        #1 bus.ch_ptr[9:5] = 5'd8;
        repeat (8) @(posedge clk);
        found = 0;
        for (int k = 0; k < 16 && !found; k++) begin
            @(negedge clk);
            if (bus.wave_valid && bus.wave_ch == 3'd1) found = 1;
        end
        check("ch1_found", found, 1);
        check("ch1_wave_q", bus.wave_q, 8'h7F);
        cpu_access(1'b0, 8'd40, 8'h00, 1);
        check("rd40_q", bus.cpu_q, 8'h7F);
        a0 = ack_cnt;
        cpu_access(1'b0, 8'd40, 8'h00, 2);
        repeat (16) @(posedge clk);
        check("hold_acks", ack_cnt - a0, 2);
        w0 = we_cnt;
        cpu_access(1'b1, 8'd200, 8'h55, 1);
        check("oor_wr_we", we_cnt - w0, 0);
        cpu_access(1'b0, 8'd170, 8'h00, 1);
        check("oor_rd_q", bus.cpu_q, 8'hFF);
        @(posedge clk); #1;
        bus.cpu_req = 1; bus.cpu_wr = 0; bus.cpu_a = 8'd40;
        for (int k = 0; k < 20 && !m_busy; k++) @(negedge clk);
        check("rst_test_accept", m_busy, 1);
        a0 = ack_cnt;
        @(posedge clk); #1 nreset = 0; bus.cpu_req = 0;
        repeat (4) @(negedge clk);
        @(posedge clk); #1 nreset = 1;
        repeat (16) @(posedge clk);
        check("rst_no_ack", ack_cnt - a0, 0);
        cpu_access(1'b0, 8'd40, 8'h00, 1);
        check("post_rst_rd_q", bus.cpu_q, 8'h7F);
        repeat (40) begin
            @(posedge clk); #1 bus.ch_ptr = 25'($urandom);
            if ($urandom_range(0, 1) == 1)
                cpu_access(1'($urandom), 8'($urandom_range(0, 199)), 8'($urandom), 1);
            else
                repeat ($urandom_range(1, 12)) @(posedge clk);
        end
        repeat (16) @(posedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
